sim_uart_rx_monitor: RTL

// Bench-side consumer of the chip's UART TX pin (cio_uart_tx_d2p). Decodes 8N1 serial frames from
// the pad-level line and buffers decoded bytes in a small FIFO with a valid/ready output. Gives the
// top-level sim bench a pad-accurate console path, independent of hierarchical taps into uart_core.

---
 rtl/sim_uart_rx_monitor_pkg.sv | 21 ++
 rtl/sim_uart_rx_monitor_if.sv | 24 ++
 rtl/sim_uart_rx_monitor_fifo.sv | 56 +++++
 rtl/sim_uart_rx_monitor.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/sim_uart_rx_monitor_pkg.sv
// Shared types and constants for the pad-level UART RX monitor.
package sim_uart_pkg;

    localparam int UartDataBits = 8;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_STOP      = 3'd3,
        RX_WAIT_IDLE = 3'd4
    } rx_state_e;

    // Per-cycle outcome flags; a bench can OR these into a sticky test status.
    typedef struct packed {
        logic frame_err;
        logic glitch;
        logic overflow;
    } uart_rx_status_t;

endpackage

// File: rtl/sim_uart_rx_monitor_if.sv
// Consumer-facing bundle of the RX monitor: decoded-byte stream plus event pulses.
// Handshake: a byte transfers on any rising clk_i where char_valid_o && char_ready_i;
// char_valid_o never depends on char_ready_i, and char_o is stable while valid is held.
interface sim_uart_rx_monitor_if #(
    parameter int FifoDepth = 8
);
    logic [7:0]                 char_o;
    logic                       char_valid_o;
    logic                       char_ready_i;
    logic [$clog2(FifoDepth):0] depth_o;
    logic                       frame_err_o;
    logic                       glitch_o;
    logic                       overflow_o;

    modport master (
        output char_o, char_valid_o, depth_o, frame_err_o, glitch_o, overflow_o,
        input  char_ready_i
    );

    modport slave (
        input  char_o, char_valid_o, depth_o, frame_err_o, glitch_o, overflow_o,
        output char_ready_i
    );
endinterface

// File: rtl/sim_uart_rx_monitor_fifo.sv
// Small synchronous byte FIFO; occupancy is the difference of pointers carrying one wrap bit.
module sim_uart_rx_fifo #(
    parameter int FifoDepth = 8,
    parameter int Width     = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [Width-1:0]           data_i,
    input  logic                       pop_i,
    output logic [Width-1:0]           data_o,
    output logic                       valid_o,
    output logic [$clog2(FifoDepth):0] depth_o,
    output logic                       overflow_o
);
    localparam int AW = $clog2(FifoDepth);

    logic [Width-1:0] mem_q [FifoDepth];
    logic [AW:0]      wr_q;
    logic [AW:0]      rd_q;
    logic             empty;
    logic             full;
    logic             do_pop;
    logic             do_push;

    assign depth_o    = wr_q - rd_q;
    assign empty      = (wr_q == rd_q);
    assign full       = (depth_o == (AW+1)'(FifoDepth));
    // Pop needs data already present: a byte pushed this cycle cannot fall through.
    assign do_pop     = pop_i && !empty;
    // When full, a simultaneous pop frees the slot the push lands in.
    assign do_push    = push_i && (!full || do_pop);
    assign overflow_o = push_i && full && !do_pop;
    assign valid_o    = !empty;
    // Head reads as zero when empty so the output is defined straight out of reset.
    assign data_o     = empty ? '0 : mem_q[rd_q[AW-1:0]];

    // Storage write; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_q[AW-1:0]] <= data_i;
        end
    end

    // Pointer update with synchronous clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
        end
    end

endmodule

// File: rtl/sim_uart_rx_monitor.sv
// Pad-level 8N1 UART receiver feeding a byte FIFO, with framing/glitch/overflow pulses.
module sim_uart_rx_monitor
    import sim_uart_pkg::*;
#(
    parameter int ClkPerBit = 16,
    parameter int FifoDepth = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         enable_i,
    input  logic                         rx_i,
    sim_uart_rx_monitor_if.master        mon,
    output rx_state_e                    state_o
);
    localparam int CntW = $clog2(ClkPerBit + 1);
    localparam logic [CntW-1:0] HalfBit = CntW'(ClkPerBit / 2 - 1);
    localparam logic [CntW-1:0] FullBit = CntW'(ClkPerBit - 1);
    localparam logic [2:0]      LastIdx = 3'(UartDataBits - 1);

    logic rx_meta;
    logic rx_s;
    logic rx_d;
    logic rx_fall;

    rx_state_e         state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [2:0]        idx_q, idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              push;
    logic              frame_err;
    logic              glitch;
    uart_rx_status_t   status;

    // Two-flop synchroniser on the asynchronous pad, plus a delay flop for edge detection.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_d    <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rx_s    <= rx_meta;
            rx_d    <= rx_s;
        end
    end

    assign rx_fall = rx_d && !rx_s;

    // Decoder state, bit timer, bit index and shift register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    // Frame decode: each sampling point is one bit-time apart, starting mid start-bit.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        push      = 1'b0;
        frame_err = 1'b0;
        glitch    = 1'b0;
        if (!enable_i) begin
            state_d = RX_IDLE;
        end else begin
            case (state_q)
                RX_IDLE: begin
                    if (rx_fall) begin
                        state_d = RX_START;
                        cnt_d   = HalfBit;
                    end
                end
                RX_START: begin
                    if (cnt_q == '0) begin
                        if (!rx_s) begin
                            state_d = RX_DATA;
                            cnt_d   = FullBit;
                            idx_d   = '0;
                        end else begin
                            glitch  = 1'b1;
                            state_d = RX_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q - CntW'(1);
                    end
                end
                RX_DATA: begin
                    if (cnt_q == '0) begin
                        shift_d[idx_q] = rx_s;
                        cnt_d          = FullBit;
                        if (idx_q == LastIdx) begin
                            state_d = RX_STOP;
                        end else begin
                            idx_d = idx_q + 3'd1;
                        end
                    end else begin
                        cnt_d = cnt_q - CntW'(1);
                    end
                end
                RX_STOP: begin
                    if (cnt_q == '0) begin
                        if (rx_s) begin
                            push    = 1'b1;
                            state_d = RX_IDLE;
                        end else begin
                            frame_err = 1'b1;
                            state_d   = RX_WAIT_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q - CntW'(1);
                    end
                end
                RX_WAIT_IDLE: begin
                    // A held-low line (break) must return high before a new start is trusted.
                    if (rx_s) state_d = RX_IDLE;
                end
                default: state_d = RX_IDLE;
            endcase
        end
    end

    sim_uart_rx_fifo #(
        .FifoDepth (FifoDepth),
        .Width     (8)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push_i     (push && !rst_i),
        .data_i     (shift_q),
        .pop_i      (mon.char_ready_i),
        .data_o     (mon.char_o),
        .valid_o    (mon.char_valid_o),
        .depth_o    (mon.depth_o),
        .overflow_o (status.overflow)
    );

    // Outcome pulses are silenced while reset is asserted, whatever state is being left.
    assign status.frame_err = frame_err && !rst_i;
    assign status.glitch    = glitch && !rst_i;

    assign mon.frame_err_o = status.frame_err;
    assign mon.glitch_o    = status.glitch;
    assign mon.overflow_o  = status.overflow;
    assign state_o         = state_q;

endmodule
